fetch_pc_unit: RTL and testbench

- Program-counter generator directly upstream of the instruction memory: drives its 16-bit Address (PC) every cycle and receives the same stall.
- Selects next PC from sequential increment, taken BEQ/FOR branch (EX stage), or decode-stage jump/call/return.
- Holds a small return-address stack (RAS) for call/return and raises kill to flush the wrong-path fetched instruction.

---
 rtl/fetch_pc_if.sv | 28 ++
 rtl/fetch_pc_unit.sv | 91 +++++++++
 tb/tb_fetch_pc_unit.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fetch_pc_if.sv
// Fetch-side bus between decode/EX request logic and the PC generator.
// The master drives redirect requests; the slave (PC unit) returns fetch address and RAS status.
interface fetch_pc_if;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        jump;
    logic        call;
    logic        ret;
    logic [15:0] jump_target;
    logic [15:0] link_addr;
    logic [15:0] pc;
    logic [15:0] pc_plus1;
    logic        kill;
    logic        ras_empty;
    logic        ras_err;
    logic        ras_ovf;

    modport master (
        output stall, branch_taken, branch_target, jump, call, ret, jump_target, link_addr,
        input  pc, pc_plus1, kill, ras_empty, ras_err, ras_ovf
    );

    modport slave (
        input  stall, branch_taken, branch_target, jump, call, ret, jump_target, link_addr,
        output pc, pc_plus1, kill, ras_empty, ras_err, ras_ovf
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Program-counter generator: sequential / branch / jump / call / return selection
// with a circular return-address stack and sticky RAS error flags.
module fetch_pc_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          RAS_DEPTH = 4,
    parameter int          RAS_PTR_W = 2
) (
    input logic       clk,
    input logic       reset,
    fetch_pc_if.slave bus
);
    localparam logic [RAS_PTR_W:0] RAS_FULL = (RAS_PTR_W+1)'(RAS_DEPTH);

    logic [15:0]          pc_q, pc_d;
    logic [RAS_PTR_W-1:0] ptr_q, ptr_d;
    logic [RAS_PTR_W:0]   cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic                 ovf_q, ovf_d;
    logic [15:0]          ras_q [RAS_DEPTH];
    logic                 push, pop, kill;

    // Branch beats stall; stalled decode requests are replayed later, so they're dropped here.
    always_comb begin
        pc_d  = pc_q + 16'd1;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        err_d = err_q;
        ovf_d = ovf_q;
        push  = 1'b0;
        pop   = 1'b0;
        kill  = 1'b0;
        if (bus.branch_taken) begin
            pc_d = bus.branch_target;
            kill = 1'b1;
        end else if (bus.stall) begin
            pc_d = pc_q;
        end else if (bus.ret) begin
            kill = 1'b1;
            if (cnt_q == '0) begin
                pc_d  = RESET_PC;
                err_d = 1'b1;
            end else begin
                pc_d  = ras_q[ptr_q];
                pop   = 1'b1;
                ptr_d = ptr_q - 1'b1;
                cnt_d = cnt_q - 1'b1;
            end
        end else if (bus.call || bus.jump) begin
            pc_d = bus.jump_target;
            kill = 1'b1;
            if (bus.call) begin
                push  = 1'b1;
                ptr_d = ptr_q + 1'b1;
                // At full the write lands on the oldest slot; depth stays saturated.
                if (cnt_q == RAS_FULL) ovf_d = 1'b1;
                else                   cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q  <= RESET_PC;
            ptr_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
            ovf_q <= ovf_d;
        end
    end

    // Storage needs no reset: entries are only read while count says they are valid.
    always_ff @(posedge clk) begin
        if (push) ras_q[ptr_d] <= bus.link_addr;
    end

    assign bus.pc        = pc_q;
    assign bus.pc_plus1  = pc_q + 16'd1;
    assign bus.kill      = kill;
    assign bus.ras_empty = (cnt_q == '0);
    assign bus.ras_err   = err_q;
    assign bus.ras_ovf   = ovf_q;

    logic unused_pop;
    assign unused_pop = pop;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: sequential fetch, stall, branch/jump/call/ret,
// RAS overflow/underflow, PC wrap and asynchronous reset.
module tb_fetch_pc_unit;
    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    fetch_pc_if bus ();

    fetch_pc_unit #(
        .RESET_PC (16'h0000),
        .RAS_DEPTH(4),
        .RAS_PTR_W(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 16'h0;
        bus.jump          = 1'b0;
        bus.call          = 1'b0;
        bus.ret           = 1'b0;
        bus.jump_target   = 16'h0;
        bus.link_addr     = 16'h0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        #12;
        chk("rst_pc", 32'(bus.pc), 32'h0000);
        chk("rst_pc_plus1", 32'(bus.pc_plus1), 32'h0001);
        chk("rst_ras_empty", 32'(bus.ras_empty), 32'h1);
        chk("rst_kill", 32'(bus.kill), 32'h0);
        chk("rst_err", 32'(bus.ras_err), 32'h0);
        chk("rst_ovf", 32'(bus.ras_ovf), 32'h0);
        #1 reset = 1'b0;

        // 1. sequential fetch and stall
        chk("seq_pc0", 32'(bus.pc), 32'h0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("seq_pc", 32'(bus.pc), 32'(i));
        end
        bus.stall = 1'b1;
        #1 chk("stall_kill", 32'(bus.kill), 32'h0);
        tick(); chk("stall_pc_a", 32'(bus.pc), 32'h3);
        tick(); chk("stall_pc_b", 32'(bus.pc), 32'h3);
        bus.stall = 1'b0;
        tick(); chk("post_stall_pc", 32'(bus.pc), 32'h4);

        // 2. taken branch with a wrong-path jump alongside
        bus.jump = 1'b1; bus.jump_target = 16'h0001;
        #1 chk("jump_kill", 32'(bus.kill), 32'h1);
        tick(); chk("jump_pc", 32'(bus.pc), 32'h1);
        bus.branch_taken = 1'b1; bus.branch_target = 16'h0002;
        bus.jump_target = 16'h000C;
        #1 chk("br_kill", 32'(bus.kill), 32'h1);
        tick(); chk("br_pc", 32'(bus.pc), 32'h2);
        chk("br_ras_empty", 32'(bus.ras_empty), 32'h1);
        idle();

        // 3. call / return
        bus.call = 1'b1; bus.jump_target = 16'h000A; bus.link_addr = 16'h0001;
        #1 chk("call_kill", 32'(bus.kill), 32'h1);
        tick(); chk("call_pc", 32'(bus.pc), 32'hA);
        chk("call_ras_empty", 32'(bus.ras_empty), 32'h0);
        idle();
        tick(); chk("call_seq_pc", 32'(bus.pc), 32'hB);
        bus.ret = 1'b1;
        #1 chk("ret_kill", 32'(bus.kill), 32'h1);
        tick(); chk("ret_pc", 32'(bus.pc), 32'h1);
        chk("ret_ras_empty", 32'(bus.ras_empty), 32'h1);
        idle();

        // 4. stall versus redirect
        bus.stall = 1'b1; bus.jump = 1'b1; bus.jump_target = 16'h000C;
        #1 chk("stall_jump_kill", 32'(bus.kill), 32'h0);
        tick(); chk("stall_jump_pc", 32'(bus.pc), 32'h1);
        bus.branch_taken = 1'b1; bus.branch_target = 16'h0005;
        #1 chk("stall_br_kill", 32'(bus.kill), 32'h1);
        tick(); chk("stall_br_pc", 32'(bus.pc), 32'h5);
        idle();

        // 5. RAS overflow then underflow
        for (int i = 1; i <= 5; i++) begin
            bus.call = 1'b1; bus.jump_target = 16'h0100 + 16'(i); bus.link_addr = 16'(i);
            tick();
        end
        idle();
        chk("ovf_flag", 32'(bus.ras_ovf), 32'h1);
        chk("ovf_pc", 32'(bus.pc), 32'h0105);
        for (int k = 0; k < 4; k++) begin
            bus.ret = 1'b1;
            tick();
            chk("ras_pop_pc", 32'(bus.pc), 32'(5 - k));
        end
        chk("pre_uf_err", 32'(bus.ras_err), 32'h0);
        chk("pre_uf_empty", 32'(bus.ras_empty), 32'h1);
        #1 chk("uf_kill", 32'(bus.kill), 32'h1);
        tick();
        chk("uf_pc", 32'(bus.pc), 32'h0);
        chk("uf_err", 32'(bus.ras_err), 32'h1);
        chk("uf_ovf_sticky", 32'(bus.ras_ovf), 32'h1);
        idle();

        // 6. wrap and asynchronous reset
        bus.jump = 1'b1; bus.jump_target = 16'hFFFF;
        tick(); chk("wrap_pc_ffff", 32'(bus.pc), 32'hFFFF);
        chk("wrap_plus1", 32'(bus.pc_plus1), 32'h0000);
        idle();
        tick(); chk("wrap_pc0", 32'(bus.pc), 32'h0000);
        tick(); tick();
        chk("pre_arst_pc", 32'(bus.pc), 32'h0002);
        bus.jump = 1'b1; bus.jump_target = 16'h0040;
        #2 reset = 1'b1;
        #1;
        chk("arst_pc", 32'(bus.pc), 32'h0000);
        chk("arst_err", 32'(bus.ras_err), 32'h0);
        chk("arst_ovf", 32'(bus.ras_ovf), 32'h0);
        chk("arst_empty", 32'(bus.ras_empty), 32'h1);
        idle();
        #1 chk("arst_kill", 32'(bus.kill), 32'h0);
        tick();
        chk("arst_hold_pc", 32'(bus.pc), 32'h0000);
        reset = 1'b0;
        tick();
        chk("post_arst_pc", 32'(bus.pc), 32'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
